// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: entry/flag layout.
// ALU_RESULT_PARITY_EN adds a parity bit to alu_flags_t.
package alu_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef struct packed {
        logic zero;
        logic neg;
        logic ovf;
`ifdef ALU_RESULT_PARITY_EN
        logic parity;
`endif
    } alu_flags_t;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] result;
        alu_flags_t                flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation for an incoming result word.
// ALU_RESULT_PARITY_EN also produces even parity of the result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] result,
    input  logic              ovf,
    output alu_flags_t        flags
);

    always_comb begin
        flags      = '0;
        flags.zero = (result == '0);
        flags.neg  = result[DATA_W-1];
        flags.ovf  = ovf;
`ifdef ALU_RESULT_PARITY_EN
        flags.parity = ^result;
`endif
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag output stage with 2-entry skid buffer and overflow status.
// ALU_RESULT_PARITY_EN adds the out_parity port.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_ovf,
    input  logic              clr_sticky,
    output logic              sticky_ovf,
    output logic [CNT_W-1:0]  ovf_count
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        alu_flags_t        flags;
    } entry_t;

    alu_flags_t in_flags;
    entry_t     in_entry;
    entry_t     out_q;
    entry_t     skid_q;
    logic       out_valid_q;
    logic       skid_full;
    logic       accept;
    logic       xfer;
    logic       ovf_event;

    alu_flag_gen #(
        .DATA_W (DATA_W)
    ) u_flag_gen (
        .result (in_result),
        .ovf    (in_ovf),
        .flags  (in_flags)
    );

    assign in_entry  = '{result: in_result, flags: in_flags};
    assign in_ready  = ~skid_full;
    assign accept    = in_valid & ~skid_full;
    assign xfer      = out_valid_q & out_ready;
    assign ovf_event = accept & in_ovf;

    // No accept is possible while the skid is full, so the branches are exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full   <= 1'b0;
        end else if (skid_full) begin
            if (xfer) begin
                out_q     <= skid_q;
                skid_full <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_q       <= in_entry;
                out_valid_q <= 1'b1;
            end else begin
                skid_q    <= in_entry;
                skid_full <= 1'b1;
            end
        end else if (xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            ovf_count  <= '0;
        end else begin
            if (ovf_event) begin
                sticky_ovf <= 1'b1;
            end else if (clr_sticky) begin
                sticky_ovf <= 1'b0;
            end

            if (clr_sticky) begin
                ovf_count <= ovf_event ? CNT_W'(1) : '0;
            end else if (ovf_event && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_q.result;
    assign out_zero   = out_q.flags.zero;
    assign out_neg    = out_q.flags.neg;
    assign out_ovf    = out_q.flags.ovf;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity = out_q.flags.parity;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: randomized traffic plus directed corner cases.
// Covers out_parity when ALU_RESULT_PARITY_EN is defined.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_neg;
    logic        out_ovf;
    logic        clr_sticky = 1'b0;
    logic        sticky_ovf;
    logic [7:0]  ovf_count;
`ifdef ALU_RESULT_PARITY_EN
    logic        out_parity;
`endif

    alu_result_stage #(
        .DATA_W (32),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .ovf_count  (ovf_count)
`ifdef ALU_RESULT_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic        exp_sticky = 1'b0;
    int          exp_cnt = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random
    int          stall_cycles = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_result = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Consumer-side ready driver
    always @(posedge clk) begin
        #1;
        if (stall_cycles > 0) begin
            out_ready = 1'b0;
            stall_cycles--;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Input-side observer: records accepted entries and the expected status registers
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                q.push_back('{r: in_result, o: in_ovf});
            end
            if (in_valid && in_ready && in_ovf) begin
                exp_sticky = 1'b1;
            end else if (clr_sticky) begin
                exp_sticky = 1'b0;
            end
            if (clr_sticky) begin
                exp_cnt = (in_valid && in_ready && in_ovf) ? 1 : 0;
            end else if (in_valid && in_ready && in_ovf) begin
                exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
            end
        end
    end

    // Output monitor: occupancy, ordering, payload, flags, stability
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            check("sticky_ovf", sticky_ovf, exp_sticky);
            check("ovf_count", ovf_count, exp_cnt);
            if (stall_prev) begin
                check("stall_stable", out_result, prev_result);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_result", out_result, e.r);
                    check("out_zero", out_zero, e.r == 0);
                    check("out_neg", out_neg, e.r >= 32'h8000_0000);
                    check("out_ovf", out_ovf, e.o);
`ifdef ALU_RESULT_PARITY_EN
                    check("out_parity", out_parity, $countones(e.r) % 2);
`endif
                end
            end
            stall_prev  = out_valid && !out_ready;
            prev_result = out_result;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_result", out_result, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_neg", out_neg, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", sticky_ovf, 0);
        check("rst_count", ovf_count, 0);
`ifdef ALU_RESULT_PARITY_EN
        check("rst_parity", out_parity, 0);
`endif
    endtask

    // Holds the word on the input until the stage can take it
    task automatic send(input logic [31:0] r, input logic o, input logic clr);
        int b;
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_result  = r;
        in_ovf     = o;
        clr_sticky = clr;
        b = 0;
        while (!in_ready && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (b == 50) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            clr_sticky = 1'b0;
        end
    endtask

    initial begin
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic flags and sticky/counter behaviour
        send(32'hFFFF_FFF6, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_0005, 1'b1, 1'b1);
        send(32'h0000_0006, 1'b0, 1'b1);
        idle(2);

        // Stalled stream 1..4
        send(32'd1, 1'b0, 1'b0);
        stall_cycles = 2;
        for (int i = 2; i <= 4; i++) send(32'(i), 1'b0, 1'b0);
        idle(4);

        // Parity patterns
        send(32'h0000_0007, 1'b0, 1'b0);
        send(32'h0000_0003, 1'b0, 1'b0);
        idle(2);

        // Counter saturation
        for (int i = 0; i < 300; i++) send($urandom, 1'b1, 1'b0);
        idle(3);

        // Random traffic with backpressure and clears
        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            case ($urandom_range(0, 5))
                0: r = 32'h0;
                1: r = 32'h8000_0000;
                default: r = $urandom;
            endcase
            send(r, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        ready_mode = 0;
        idle(6);

        // Reset with both output and skid occupied
        stall_cycles = 20;
        send(32'hDEAD_0001, 1'b1, 1'b0);
        send(32'hDEAD_0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("pre_rst_in_ready", in_ready, 0);
        check("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        exp_sticky   = 1'b0;
        exp_cnt      = 0;
        stall_cycles = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        send(32'h0000_1234, 1'b0, 1'b0);
        send(32'h8765_4321, 1'b1, 1'b0);
        idle(8);

        check("drain_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
